mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, gives the max cycles to wait for mem_ack before aborting (1..255).
REQ-002 clk  in  1  clock shared with the CPU and caches; single clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_mem_r  in  1  I-cache line-refill request; held high until i_mem_ready.
REQ-005 i_mem_addr  in  32  I-cache line address, bits [3:0] zero.
REQ-006 i_mem_ready  out  1  one-cycle pulse: I refill done, i_mem_data valid.
REQ-007 i_mem_data  out  128  refill line to the I-cache.
REQ-008 d_mem_r  in  1  D-cache line read request; held until d_mem_ready.
REQ-009 d_mem_w  in  1  D-cache line writeback request; held until d_mem_ready; never high with d_mem_r.
REQ-010 d_mem_addr  in  32  D-cache line address, bits [3:0] zero.
REQ-011 d_mem_wdata  in  128  writeback line.
REQ-012 d_mem_ready  out  1  one-cycle pulse: D transfer done.
REQ-013 d_mem_data  out  128  read line to the D-cache.
REQ-014 mem_req  out  1  request to main memory, held until mem_ack.
REQ-015 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-016 mem_addr  out  32  line address to memory.
REQ-017 mem_wdata  out  128  write line to memory.
REQ-018 mem_ack  in  1  one-cycle completion pulse from memory; mem_rdata valid on a read.
REQ-019 mem_rdata  in  128  read line from memory.
REQ-020 mem_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states are IDLE, GRANT_I, GRANT_D, DONE.
- IDLE -> GRANT_I or GRANT_D on a valid request.
- GRANT_x -> DONE on mem_ack or timeout.
- DONE -> IDLE unconditionally.
REQ-022 Arbitration in IDLE is round-robin on a 1-bit last_grant register.
- If both sides request, grant the side not granted last.
- If only one side requests, grant it.
- last_grant updates on entry to GRANT_x.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata are registered; they are driven on the cycle after the grant decision and held stable until mem_ack.
REQ-024 On mem_ack in GRANT_I:
- i_mem_data captures mem_rdata.
- i_mem_ready pulses high for exactly the next cycle (in DONE).
- mem_req drops that same next cycle.
REQ-025 GRANT_D behaves like REQ-024 using the d_ side; mem_we equals d_mem_w latched at grant.
REQ-026 The requester served last is masked in DONE and in the following IDLE cycle, so a request still high because of its one-cycle deassert lag is never re-granted.
REQ-027 i_mem_data and d_mem_data hold their last captured value until the next capture on the same side.
REQ-028 A timeout counter is 8-bit and clears on grant entry.
- It increments each GRANT_x cycle without mem_ack.
- On reaching TIMEOUT: mem_err pulses one cycle and the FSM enters DONE.
- The granted side's ready pulses with stale data so it cannot hang.
REQ-029 mem_ack has priority over timeout when both occur in the same cycle; no mem_err is raised.
REQ-030 mem_ack in IDLE or DONE is ignored: no ready pulse, no data capture.
REQ-031 Worst-case latency is 1 grant cycle + memory latency + 1 DONE cycle; with an immediate ack it is 3 cycles from request to ready.

Reset
REQ-032 While rst is high the FSM is IDLE and last_grant = 1 (I side wins the first tie).
REQ-033 While rst is high all these outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_mem_ready, d_mem_ready, i_mem_data, d_mem_data, mem_err.
REQ-034 rst asserted mid-transfer drops mem_req the next cycle, with no ready pulse to either side.

Structure
REQ-035 The shared package holds the state encoding (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10, DONE=2'b11), LINE_W=128 and ADDR_W=32.
REQ-036 A single sub-module, rr_arb2, implements the 2-way round-robin pick from the masked requests and last_grant.

Verification
REQ-037 I-only request at 0x0000_1230 with ack after 4 cycles:
- mem_addr = 0x0000_1230, mem_we = 0.
- i_mem_ready pulses once with i_mem_data = mem_rdata.
REQ-038 Simultaneous I and D requests after reset:
- I is served first, then D.
- Two mem_req phases, each ready pulses once.
REQ-039 D writeback to 0x0000_8000 with wdata 0xA5..A5: mem_we = 1 and mem_wdata matches during mem_req.
REQ-040 I request still high in the cycle after i_mem_ready, with D requesting: D is granted next and no second I grant occurs.
REQ-041 Ack withheld with TIMEOUT = 8:
- mem_err pulses on the 8th GRANT cycle.
- The granted side's ready pulses, then IDLE.
REQ-042 rst asserted during GRANT_D: mem_req = 0 next cycle, no d_mem_ready, and the next grant after reset on a tie goes to I.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache to main-memory arbiter.
// The state encoding is fixed so debug tools and checkers can decode it directly.
package mem_arbiter_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;

  // Side encoding used by last_grant and the round-robin pick.
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    DONE    = 2'b11
  } arb_state_e;

  function automatic logic is_grant(input arb_state_e s);
    return (s == GRANT_I) || (s == GRANT_D);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: bit 0 of req is the I side, bit 1 the D side.
// On a tie the side that was not granted last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_side
);

  // Combinational pick from the already-masked request vector.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_side  = SIDE_I;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_side  = SIDE_I;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_side  = SIDE_D;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_side  = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_side  = SIDE_I;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache reads/writebacks onto one memory port,
// with round-robin fairness, an ack timeout and a registered memory interface.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_r,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  output logic [LINE_W-1:0] i_mem_data,
  input  logic              d_mem_r,
  input  logic              d_mem_w,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [LINE_W-1:0] d_mem_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

  arb_state_e state_r;
  arb_state_e next_state;
  logic       last_grant_r;
  logic       after_done_r;
  logic [7:0] tmo_cnt_r;
  logic       mask_on;
  logic [1:0] req_masked;
  logic       gnt_valid;
  logic       gnt_side;
  logic       in_grant;
  logic       timeout_hit;
  logic       finish_xfer;
  logic       grant_take;

  // Request masking and transfer-completion decode.
  always_comb begin
    // The side just served may still hold its request for one cycle after its
    // ready pulse; hide it through DONE and the IDLE cycle that follows.
    mask_on       = (state_r == DONE) || after_done_r;
    req_masked[0] = i_mem_r && !(mask_on && (last_grant_r == SIDE_I));
    req_masked[1] = (d_mem_r || d_mem_w) && !(mask_on && (last_grant_r == SIDE_D));
    in_grant      = is_grant(state_r);
    timeout_hit   = in_grant && !mem_ack && (tmo_cnt_r == TMO_LAST);
    finish_xfer   = in_grant && (mem_ack || timeout_hit);
    grant_take    = (state_r == IDLE) && gnt_valid;
  end

  rr_arb2 u_rr_arb2 (
    .req        (req_masked),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid),
    .gnt_side   (gnt_side)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid) begin
          next_state = (gnt_side == SIDE_D) ? GRANT_D : GRANT_I;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (finish_xfer) begin
          next_state = DONE;
        end else begin
          next_state = state_r;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arbitration history, DONE follow-up flag and the ack timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= SIDE_D;
      after_done_r <= 1'b0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      after_done_r <= (state_r == DONE);
      if (grant_take) begin
        last_grant_r <= gnt_side;
        tmo_cnt_r    <= 8'd0;
      end else if (in_grant && !mem_ack) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end
    end
  end

  // Memory-side request registers, loaded at grant and held until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {LINE_W{1'b0}};
    end else if (grant_take) begin
      mem_req   <= 1'b1;
      mem_we    <= (gnt_side == SIDE_D) ? d_mem_w : 1'b0;
      mem_addr  <= (gnt_side == SIDE_D) ? d_mem_addr : i_mem_addr;
      mem_wdata <= (gnt_side == SIDE_D) ? d_mem_wdata : {LINE_W{1'b0}};
    end else if (finish_xfer) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Cache-side responses: one-cycle ready/err pulses and per-side data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      mem_err     <= 1'b0;
      i_mem_data  <= {LINE_W{1'b0}};
      d_mem_data  <= {LINE_W{1'b0}};
    end else begin
      i_mem_ready <= finish_xfer && (state_r == GRANT_I);
      d_mem_ready <= finish_xfer && (state_r == GRANT_D);
      mem_err     <= timeout_hit;
      // On timeout the data registers keep their stale line.
      if ((state_r == GRANT_I) && mem_ack) begin
        i_mem_data <= mem_rdata;
      end
      if ((state_r == GRANT_D) && mem_ack) begin
        d_mem_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory phases and
// cache responses into queues; negedge monitors pop and compare them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_r, i_mem_ready;
  logic [31:0]  i_mem_addr;
  logic [127:0] i_mem_data;
  logic         d_mem_r, d_mem_w, d_mem_ready;
  logic [31:0]  d_mem_addr;
  logic [127:0] d_mem_wdata, d_mem_data;
  logic         mem_req, mem_we, mem_ack, mem_err;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_mem_r(i_mem_r), .i_mem_addr(i_mem_addr), .i_mem_ready(i_mem_ready), .i_mem_data(i_mem_data),
    .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_ready(d_mem_ready), .d_mem_data(d_mem_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [127:0] wdata; } mem_exp_t;
  typedef struct { logic side; logic [127:0] data; logic err; } rsp_exp_t;

  mem_exp_t     exp_mem[$];
  rsp_exp_t     exp_rsp[$];
  logic [127:0] rd_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int ack_dly = 1, ack_en = 1, wait_cnt = 0, acked = 0;
  int i_lag = 0, d_lag = 0, i_hold = 0, d_hold = 0;
  int last_i_ready_cyc = 0, req_cyc = 0, phase_len = 0, last_len = 0;
  logic     mem_req_prev = 1'b0;
  mem_exp_t cur_mem;

  localparam logic [127:0] R1 = 128'h1111_0000_0000_0000_0000_0000_0000_1111;
  localparam logic [127:0] R1B = 128'h1B1B_0000_0000_0000_0000_0000_0000_1B1B;
  localparam logic [127:0] R2 = 128'h2222_2222_0000_0000_0000_0000_2222_2222;
  localparam logic [127:0] R3 = 128'h3333_3333_3333_0000_0000_3333_3333_3333;
  localparam logic [127:0] R4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
  localparam logic [127:0] R5 = 128'h5555_0000_5555_0000_5555_0000_5555_0000;
  localparam logic [127:0] R6 = 128'h6666_1234_6666_1234_6666_1234_6666_1234;
  localparam logic [127:0] R7 = 128'h7777_ABCD_7777_ABCD_7777_ABCD_7777_ABCD;
  localparam logic [127:0] R8 = 128'h8888_0001_8888_0002_8888_0003_8888_0004;
  localparam logic [127:0] R9 = 128'h9999_FFFF_9999_EEEE_9999_DDDD_9999_CCCC;
  localparam logic [127:0] WA5 = {16{8'hA5}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic drained = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_mem.size() == 0 && exp_rsp.size() == 0 && !i_mem_r && !d_mem_r && !d_mem_w && !mem_req) begin
        drained = 1'b1;
        break;
      end
      tick(1);
    end
    chk("drain_in_budget", drained, 1'b1);
    tick(3);
  endtask

  task automatic push_mem(input logic [31:0] a, input logic we, input logic [127:0] wd);
    exp_mem.push_back('{addr: a, we: we, wdata: wd});
  endtask

  task automatic push_rsp(input logic side, input logic [127:0] data, input logic err);
    exp_rsp.push_back('{side: side, data: data, err: err});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: ack on the ack_dly-th cycle of each mem_req phase.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 128'd0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) begin
        wait_cnt = 0;
        acked = 0;
      end else if (acked == 0) begin
        wait_cnt++;
        if (ack_en != 0 && wait_cnt == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 128'd0;
          acked = 1;
        end
      end
    end
  end

  // Requesters drop their request lag cycles after seeing ready.
  initial forever begin
    @(posedge clk); #1;
    if (i_hold > 0) begin
      i_hold--;
      if (i_hold == 0) i_mem_r = 1'b0;
    end
    if (d_hold > 0) begin
      d_hold--;
      if (d_hold == 0) begin
        d_mem_r = 1'b0;
        d_mem_w = 1'b0;
      end
    end
  end

  // Monitor: memory phases and cache responses against the scoreboard.
  initial forever begin
    rsp_exp_t r;
    @(negedge clk);
    if (mem_req && !mem_req_prev) begin
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_phase_unexpected: addr %h we %b, no phase expected", mem_addr, mem_we);
        cur_mem = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
      end else begin
        cur_mem = exp_mem.pop_front();
      end
    end
    if (mem_req) begin
      chk("mem_addr", mem_addr, cur_mem.addr);
      chk("mem_we", mem_we, cur_mem.we);
      chk("mem_wdata", mem_wdata, cur_mem.wdata);
      phase_len++;
    end else if (mem_req_prev) begin
      last_len = phase_len;
      phase_len = 0;
    end
    mem_req_prev = mem_req;
    if (i_mem_ready || d_mem_ready || mem_err) begin
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: i_ready %b d_ready %b err %b, none expected", i_mem_ready, d_mem_ready, mem_err);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_one_ready", i_mem_ready ^ d_mem_ready, 1'b1);
        chk("rsp_side", d_mem_ready, r.side);
        chk("rsp_data", d_mem_ready ? d_mem_data : i_mem_data, r.data);
        chk("rsp_err", mem_err, r.err);
      end
    end
    if (i_mem_ready) begin
      i_hold = i_lag + 1;
      last_i_ready_cyc = cyc;
    end
    if (d_mem_ready) d_hold = d_lag + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic got_req;
    rst = 1'b1;
    i_mem_r = 1'b0; i_mem_addr = 32'd0;
    d_mem_r = 1'b0; d_mem_w = 1'b0; d_mem_addr = 32'd0; d_mem_wdata = 128'd0;
    tick(3);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    chk("rst_i_ready", i_mem_ready, 1'b0);
    chk("rst_d_ready", d_mem_ready, 1'b0);
    chk("rst_i_data", i_mem_data, 128'd0);
    chk("rst_d_data", d_mem_data, 128'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    rst = 1'b0;
    tick(1);

    // I-only refill, ack on the 4th grant cycle.
    ack_dly = 4;
    push_mem(32'h0000_1230, 1'b0, 128'd0); push_rsp(SIDE_I, R1, 1'b0); rd_q.push_back(R1);
    i_mem_addr = 32'h0000_1230; i_mem_r = 1'b1;
    wait_idle();
    chk("t1_phase_len", 128'(last_len), 128'd4);

    // Immediate ack: ready two cycles after the request cycle.
    ack_dly = 1;
    push_mem(32'h0000_1240, 1'b0, 128'd0); push_rsp(SIDE_I, R1B, 1'b0); rd_q.push_back(R1B);
    i_mem_addr = 32'h0000_1240; i_mem_r = 1'b1; req_cyc = cyc;
    wait_idle();
    chk("latency_req_to_ready", 128'(last_i_ready_cyc - req_cyc), 128'd2);

    // Tie right after reset: I first, then D.
    rst = 1'b1; tick(2); rst = 1'b0;
    ack_dly = 2;
    push_mem(32'h0000_2000, 1'b0, 128'd0); push_mem(32'h0000_3000, 1'b0, 128'd0);
    push_rsp(SIDE_I, R2, 1'b0); push_rsp(SIDE_D, R3, 1'b0);
    rd_q.push_back(R2); rd_q.push_back(R3);
    i_mem_addr = 32'h0000_2000; d_mem_addr = 32'h0000_3000;
    i_mem_r = 1'b1; d_mem_r = 1'b1;
    wait_idle();

    // D writeback; memory returns the old D line so d_mem_data is unchanged.
    ack_dly = 3;
    push_mem(32'h0000_8000, 1'b1, WA5); push_rsp(SIDE_D, R3, 1'b0); rd_q.push_back(R3);
    d_mem_addr = 32'h0000_8000; d_mem_wdata = WA5; d_mem_w = 1'b1;
    wait_idle();
    d_mem_wdata = 128'd0;
    chk("i_data_held", i_mem_data, R2);

    // Tie after a D grant goes to I; I lags one cycle, D must be granted next.
    i_lag = 1; ack_dly = 2;
    push_mem(32'h0000_4000, 1'b0, 128'd0); push_mem(32'h0000_5000, 1'b0, 128'd0);
    push_rsp(SIDE_I, R4, 1'b0); push_rsp(SIDE_D, R5, 1'b0);
    rd_q.push_back(R4); rd_q.push_back(R5);
    i_mem_addr = 32'h0000_4000; d_mem_addr = 32'h0000_5000;
    i_mem_r = 1'b1; d_mem_r = 1'b1;
    wait_idle();

    // Lagging I request alone must not be re-granted.
    push_mem(32'h0000_6000, 1'b0, 128'd0); push_rsp(SIDE_I, R6, 1'b0); rd_q.push_back(R6);
    i_mem_addr = 32'h0000_6000; i_mem_r = 1'b1;
    wait_idle();
    tick(4);
    i_lag = 0;

    // Ack withheld: err on timeout, stale I line returned.
    ack_en = 0;
    push_mem(32'h0000_7000, 1'b0, 128'd0); push_rsp(SIDE_I, R6, 1'b1);
    i_mem_addr = 32'h0000_7000; i_mem_r = 1'b1;
    wait_idle();
    chk("timeout_phase_len", 128'(last_len), 128'(TMO));
    ack_en = 1;

    // Ack in the same cycle the timeout would fire: ack wins, no err.
    ack_dly = 8;
    push_mem(32'h0000_9000, 1'b0, 128'd0); push_rsp(SIDE_D, R7, 1'b0); rd_q.push_back(R7);
    d_mem_addr = 32'h0000_9000; d_mem_r = 1'b1;
    wait_idle();
    chk("ack_at_limit_len", 128'(last_len), 128'(TMO));

    // Reset during GRANT_D: mem_req drops, no ready, then tie goes to I.
    ack_en = 0;
    push_mem(32'h0000_A000, 1'b0, 128'd0);
    d_mem_addr = 32'h0000_A000; d_mem_r = 1'b1;
    got_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) begin
        got_req = 1'b1;
        break;
      end
      tick(1);
    end
    chk("rst_case_req_seen", got_req, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_d_ready", d_mem_ready, 1'b0);
    tick(1);
    rst = 1'b0; ack_en = 1; ack_dly = 1;
    push_mem(32'h0000_B000, 1'b0, 128'd0); push_mem(32'h0000_A000, 1'b0, 128'd0);
    push_rsp(SIDE_I, R8, 1'b0); push_rsp(SIDE_D, R9, 1'b0);
    rd_q.push_back(R8); rd_q.push_back(R9);
    i_mem_addr = 32'h0000_B000; i_mem_r = 1'b1;
    wait_idle();

    chk("end_mem_queue_empty", 128'(exp_mem.size()), 128'd0);
    chk("end_rsp_queue_empty", 128'(exp_rsp.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
